// File: rtl/sar_controller_pkg.sv
// sar_controller_pkg: shared SAR state encoding and default resolution (also used by the UART readout stage)
package sar_controller_pkg;
  localparam int SAR_WIDTH_DEFAULT = 12;
  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, BIT = 2'd2, DONE = 2'd3} sar_state_e;
endpackage

// File: rtl/sar_controller_sync_2ff.sv
// sync_2ff: two-flop synchronizer; clk_i/reset_ni (async active-low, clears to 0), d in, q out two cycles later
module sync_2ff (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/sar_controller.sv
// sar_controller: SAR ADC conversion FSM; in clk_i/reset_ni/start_i/comp_i, out dac_o trial code, track_o S&H, busy_o, sample_o result, ready_o pulse
module sar_controller
  import sar_controller_pkg::*;
#(
  parameter int WIDTH         = SAR_WIDTH_DEFAULT,
  parameter int SAMPLE_CYCLES = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             comp_i,
  output logic [WIDTH-1:0] dac_o,
  output logic             track_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] sample_o,
  output logic             ready_o
);
  localparam int CNT_MAX = SAMPLE_CYCLES > SETTLE_CYCLES ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int IW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  if (SETTLE_CYCLES < 2) begin : g_settle_check
    $error("SETTLE_CYCLES must be >= 2 to cover the comparator synchronizer");
  end
  sar_state_e state_q, state_d;
  logic start_q, comp_s, trig, last;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] result, res_bit;
  sync_2ff u_sync (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .d        (comp_i),
    .q        (comp_s)
  );
  assign trig = start_i & ~start_q;
  assign last = cnt == '0;
  assign res_bit = result | (WIDTH'(comp_s) << idx);
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = trig ? TRACK : IDLE;
      TRACK:   state_d = last ? BIT : TRACK;
      BIT:     state_d = last && idx == '0 ? DONE : BIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_o  = state_q != IDLE;
    track_o = state_q == TRACK;
    ready_o = state_q == DONE;
  end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      start_q  <= 1'b0;
      cnt      <= '0;
      idx      <= '0;
      result   <= '0;
      dac_o    <= '0;
      sample_o <= '0;
    end else begin
      start_q <= start_i;
      case (state_q)
        IDLE: if (trig) begin
          cnt    <= CW'(SAMPLE_CYCLES - 1);
          result <= '0;
          dac_o  <= '0;
        end
        TRACK: if (last) begin
          cnt   <= CW'(SETTLE_CYCLES);
          idx   <= IW'(WIDTH - 1);
          dac_o <= ONE << (WIDTH - 1);
        end else cnt <= cnt - 1'b1;
        BIT: if (!last) cnt <= cnt - 1'b1;
        else begin
          cnt    <= CW'(SETTLE_CYCLES);
          result <= res_bit;
          idx    <= idx - 1'b1;
          dac_o  <= idx == '0 ? res_bit : res_bit | (ONE << (idx - 1'b1));
          if (idx == '0) sample_o <= res_bit;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_sar_controller.sv
// tb_sar_controller: randomized self-checking bench for sar_controller against an ideal binary-search ADC model
module tb_sar_controller;
  localparam int W = 12, SC = 16, ST = 4;
  localparam int LAT = SC + W * (ST + 1) + 1;
  logic clk_i = 0, reset_ni = 1, start_i = 0, comp_i;
  logic [W-1:0] dac_o, sample_o;
  logic track_o, busy_o, ready_o;
  int total = 0, bad = 0, cyc = 0, ready_cnt = 0, mode = 0;
  logic [W-1:0] vin = '0, prev_dac = '0;
  logic comp_r = 0;
  logic [W-1:0] trials[$];
  int r_lat, r_track, r_c0;
  bit r_busy_ok, r_stable, r_post_ok;
  logic [W-1:0] r_sample, r_dac;
  sar_controller #(.WIDTH(W), .SAMPLE_CYCLES(SC), .SETTLE_CYCLES(ST)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .start_i  (start_i),
    .comp_i   (comp_i),
    .dac_o    (dac_o),
    .track_o  (track_o),
    .busy_o   (busy_o),
    .sample_o (sample_o),
    .ready_o  (ready_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;
  always_comb comp_i = (mode == 2) ? (vin >= dac_o) : (mode == 1) ? 1'b1 : (mode == 3) ? comp_r : 1'b0;
  always @(negedge clk_i) begin
    if (ready_o) ready_cnt++;
    if (busy_o && !track_o && !ready_o && dac_o != prev_dac) trials.push_back(dac_o);
    prev_dac = dac_o;
  end
  function automatic logic [W-1:0] trial_of(logic [W-1:0] v, int k);
    int b = W - 1 - k;
    int vi = int'(v);
    return W'(((vi >> (b + 1)) << (b + 1)) | (1 << b));
  endfunction
  function automatic bit trials_match(logic [W-1:0] v);
    if (trials.size() != W) return 0;
    for (int k = 0; k < W; k++) if (trials[k] !== trial_of(v, k)) return 0;
    return 1;
  endfunction
  task automatic run_conv(input logic hold, input int poke);
    logic [W-1:0] s0;
    s0 = sample_o;
    trials.delete();
    r_lat = -1; r_track = 0; r_busy_ok = 1; r_stable = 1;
    start_i = 1;
    @(posedge clk_i);
    #1 r_c0 = cyc;
    for (int n = 1; n <= 2 * LAT && r_lat < 0; n++) begin
      @(negedge clk_i);
      if (n == poke) start_i = 1;
      else if (n == 1 || n == poke + 1) start_i = hold;
      r_track += int'(track_o);
      if (!busy_o) r_busy_ok = 0;
      if (!ready_o && sample_o !== s0) r_stable = 0;
      if (ready_o) begin r_lat = n; r_sample = sample_o; r_dac = dac_o; end
    end
    @(negedge clk_i);
    r_post_ok = !ready_o && !busy_o;
  endtask
  task automatic test_reset;
    bit zero_ok = 1, busy_seen = 0;
    int r0;
    mode = 3;
    #2 reset_ni = 0;
    repeat (10) begin
      @(negedge clk_i);
      start_i = 1'($urandom_range(1));
      comp_r = 1'($urandom_range(1));
      #1 if ({dac_o, sample_o, track_o, busy_o, ready_o} !== '0) zero_ok = 0;
    end
    total++; if (!zero_ok) begin bad++; $display("FAIL reset_outputs: dac=%h sample=%h track=%b busy=%b ready=%b, want all 0", dac_o, sample_o, track_o, busy_o, ready_o); end
    start_i = 0; comp_r = 0; mode = 0;
    @(negedge clk_i) reset_ni = 1;
    r0 = ready_cnt;
    repeat (20) begin @(negedge clk_i); if (busy_o) busy_seen = 1; end
    #1;
    total++; if (ready_cnt != r0) begin bad++; $display("FAIL reset_idle_ready: got %0d pulses want 0", ready_cnt - r0); end
    total++; if (busy_seen) begin bad++; $display("FAIL reset_idle_busy: busy seen high, want low"); end
  endtask
  task automatic test_midscale;
    mode = 2; vin = 12'hA5C;
    @(negedge clk_i);
    run_conv(0, 0);
    total++; if (trials.size() == 0 || trials[0] !== 12'h800) begin bad++; $display("FAIL mid_first_trial: got %h want 800", trials.size() ? trials[0] : 'x); end
    total++; if (r_lat != LAT) begin bad++; $display("FAIL mid_latency: got %0d want %0d", r_lat, LAT); end
    total++; if (r_sample !== 12'hA5C) begin bad++; $display("FAIL mid_sample: got %h want a5c", r_sample); end
    total++; if (r_dac !== 12'hA5C) begin bad++; $display("FAIL mid_dac: got %h want a5c", r_dac); end
    total++; if (r_track != SC) begin bad++; $display("FAIL mid_track_len: got %0d want %0d", r_track, SC); end
    total++; if (!r_busy_ok) begin bad++; $display("FAIL mid_busy: busy dropped during conversion, want high"); end
    total++; if (!r_stable) begin bad++; $display("FAIL mid_hold: sample_o changed before ready, want held"); end
    total++; if (!r_post_ok) begin bad++; $display("FAIL mid_post: ready=%b busy=%b after DONE, want 0 0", ready_o, busy_o); end
    total++; if (!trials_match(12'hA5C)) begin bad++; $display("FAIL mid_trials: got %0d trials, sequence differs from binary search of a5c", trials.size()); end
  endtask
  task automatic test_extremes;
    mode = 1;
    @(negedge clk_i);
    run_conv(0, 0);
    total++; if (r_lat != LAT || r_sample !== 12'hFFF) begin bad++; $display("FAIL ext_high: got %h lat %0d want fff lat %0d", r_sample, r_lat, LAT); end
    total++; if (!trials_match(12'hFFF)) begin bad++; $display("FAIL ext_high_trials: got %0d trials, want 800,c00,...,fff", trials.size()); end
    mode = 0;
    @(negedge clk_i);
    run_conv(0, 0);
    total++; if (r_lat != LAT || r_sample !== 12'h000) begin bad++; $display("FAIL ext_low: got %h lat %0d want 000 lat %0d", r_sample, r_lat, LAT); end
    total++; if (!trials_match(12'h000)) begin bad++; $display("FAIL ext_low_trials: got %0d trials, want 800,400,...,001", trials.size()); end
    total++; if (dac_o !== 12'h000) begin bad++; $display("FAIL ext_low_dac: got %h want 000", dac_o); end
  endtask
  task automatic test_random;
    mode = 2;
    for (int i = 0; i < 6; i++) begin
      vin = W'($urandom_range(4095));
      @(negedge clk_i);
      run_conv(0, 0);
      total++; if (r_lat != LAT || r_sample !== vin) begin bad++; $display("FAIL rand_%0d: got %h lat %0d want %h lat %0d", i, r_sample, r_lat, vin, LAT); end
    end
  endtask
  task automatic test_held_start;
    int r0;
    mode = 2; vin = W'($urandom_range(4095));
    r0 = ready_cnt;
    @(negedge clk_i);
    run_conv(1, 0);
    repeat (300 - LAT - 2) @(negedge clk_i);
    #1;
    total++; if (ready_cnt - r0 != 1 || busy_o) begin bad++; $display("FAIL held_start: got %0d pulses busy=%b want 1 pulse busy=0", ready_cnt - r0, busy_o); end
    total++; if (r_sample !== vin) begin bad++; $display("FAIL held_sample: got %h want %h", r_sample, vin); end
    start_i = 0;
  endtask
  task automatic test_edge_in_bit;
    int r0;
    bit busy_seen = 0;
    mode = 2; vin = W'($urandom_range(4095));
    r0 = ready_cnt;
    @(negedge clk_i);
    run_conv(0, 40);
    total++; if (r_lat != LAT || r_sample !== vin) begin bad++; $display("FAIL bit_edge_conv: got %h lat %0d want %h lat %0d", r_sample, r_lat, vin, LAT); end
    repeat (100) begin @(negedge clk_i); if (busy_o) busy_seen = 1; end
    #1;
    total++; if (ready_cnt - r0 != 1 || busy_seen) begin bad++; $display("FAIL bit_edge_dropped: got %0d pulses busy_seen=%b want 1 pulse no busy", ready_cnt - r0, busy_seen); end
  endtask
  task automatic test_edge_in_done;
    int r0;
    bit busy_seen = 0;
    mode = 2; vin = W'($urandom_range(4095));
    r0 = ready_cnt;
    @(negedge clk_i);
    run_conv(0, LAT);
    total++; if (!r_post_ok) begin bad++; $display("FAIL done_edge_post: ready=%b busy=%b want 0 0", ready_o, busy_o); end
    repeat (100) begin @(negedge clk_i); if (busy_o) busy_seen = 1; end
    #1;
    total++; if (ready_cnt - r0 != 1 || busy_seen) begin bad++; $display("FAIL done_edge_ignored: got %0d pulses busy_seen=%b want 1 pulse no busy", ready_cnt - r0, busy_seen); end
    start_i = 0;
  endtask
  task automatic test_reset_mid;
    int r0;
    mode = 2; vin = 12'hABC;
    @(negedge clk_i) start_i = 1;
    @(posedge clk_i);
    @(negedge clk_i) start_i = 0;
    repeat (SC + 6 * (ST + 1) + 2) @(negedge clk_i);
    total++; if (!busy_o || dac_o !== trial_of(vin, 6)) begin bad++; $display("FAIL rmid_index5: busy=%b dac=%h want busy=1 dac=%h", busy_o, dac_o, trial_of(vin, 6)); end
    r0 = ready_cnt;
    #2 reset_ni = 0;
    #1;
    total++; if ({dac_o, sample_o, track_o, busy_o, ready_o} !== '0) begin bad++; $display("FAIL rmid_async: dac=%h sample=%h track=%b busy=%b ready=%b want all 0", dac_o, sample_o, track_o, busy_o, ready_o); end
    repeat (3) @(negedge clk_i);
    reset_ni = 1;
    repeat (20) @(negedge clk_i);
    #1;
    total++; if (ready_cnt != r0) begin bad++; $display("FAIL rmid_no_ready: got %0d pulses want 0", ready_cnt - r0); end
    vin = 12'h123;
    @(negedge clk_i);
    run_conv(0, 0);
    total++; if (r_lat != LAT || r_sample !== 12'h123) begin bad++; $display("FAIL rmid_next: got %h lat %0d want 123 lat %0d", r_sample, r_lat, LAT); end
  endtask
  task automatic test_back_to_back;
    int prev_c0 = 0;
    mode = 2;
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      vin = W'($urandom_range(4095));
      run_conv(0, 0);
      total++; if (r_lat != LAT || r_sample !== vin || !r_stable) begin bad++; $display("FAIL b2b_%0d: got %h lat %0d stable=%b want %h lat %0d stable=1", i, r_sample, r_lat, r_stable, vin, LAT); end
      if (i > 0) begin
        total++; if (r_c0 - prev_c0 != LAT + 1) begin bad++; $display("FAIL b2b_spacing_%0d: got %0d cycles want %0d", i, r_c0 - prev_c0, LAT + 1); end
      end
      prev_c0 = r_c0;
    end
  endtask
  initial begin
    test_reset;
    test_midscale;
    test_extremes;
    test_random;
    test_held_start;
    test_edge_in_bit;
    test_edge_in_done;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
